vend_reset_seq: RTL and testbench
=================================

// Module: vend_reset_seq
// PURPOSE
//  Reset sequencer for the vending datapath; it consumes the board reset and
//  auto-reset requests that the vending FSM raises after each transaction.
//  Board reset asserts asynchronously, releases synchronously, then stretches.
//  Auto-reset requests are served over a 4-phase req/ack handshake.
//  Sits between the board reset pin and every vending FSM / coin-counter reset.
// PARAMETERS
//  HOLD_CYCLES     16   clk cycles sys_rst_n held low after rst_n release (>=1)
//  PULSE_CYCLES     4   width of auto-reset pulse on sys_rst_n, clk cycles (>=1)
//  TIMEOUT_CYCLES 255   ACK-phase timeout; used only with VEND_RST_TIMEOUT_EN
//  CNT_W            8   width of auto_cnt
// PORTS
//  clk        in   1      system clock
//  rst_n      in   1      reset, asynchronous, active-low
//  req        in   1      auto-reset request, async to clk, level (4-phase)
//  sys_rst_n  out  1      registered reset to downstream logic, active-low
//  ack        out  1      handshake ack; high from pulse end until req seen low
//  busy       out  1      high in HOLD and ASSERT states
//  auto_cnt   out  CNT_W  number of completed auto-reset pulses, saturating
//  err        out  1      sticky ACK timeout flag (constant 0 if macro off)
// BEHAVIOUR
//  rst_n low (any time, mid-pulse included): immediately state=HOLD,
//   sys_rst_n=0, busy=1, ack=0, err=0, auto_cnt=0, sync FFs=0, counter=0.
//  rst_n release: 2-FF reset synchronizer, then internal counter counts
//   HOLD_CYCLES. sys_rst_n rises on clk edge 2+HOLD_CYCLES after rst_n rises.
//   Then state=IDLE, busy=0.
//  req: 2-FF synchronizer -> req_s. No edge detect; level semantics.
//  FSM states: HOLD, IDLE, ASSERT, ACK.
//   HOLD  : exit to IDLE when count hits HOLD_CYCLES; req ignored.
//   IDLE  : req_s=1 -> ASSERT. sys_rst_n falls on the 3rd clk edge after req
//           is first sampled high (2 sync + 1 FSM).
//   ASSERT: sys_rst_n=0, busy=1 for exactly PULSE_CYCLES cycles. On exit,
//           auto_cnt += 1 (saturates at 2^CNT_W-1), go to ACK.
//   ACK   : sys_rst_n=1, ack=1, busy=0. req_s=0 -> IDLE, ack=0 on that edge.
//  req dropping during ASSERT: pulse still completes full width; the ACK
//   phase then lasts 1 cycle.
//  req stuck high: exactly one pulse; stays in ACK (no retrigger).
//  req high when HOLD ends: IDLE is entered, then ASSERT on the next edge.
//  Counter width = $clog2(max(HOLD,PULSE,TIMEOUT)+1). It is cleared on every
//   state entry.
//  All outputs registered; no combinational path from req to any output.
// CONFIGURATION
//  VEND_RST_TIMEOUT_EN defined: in ACK the counter runs. If req_s is still 1
//   after TIMEOUT_CYCLES cycles: err<=1 (sticky until rst_n), ack<=0, go to
//   IDLE. IDLE then re-arms only after req_s has been seen 0 for at least
//   1 cycle.
//  Undefined: no timeout logic; ACK waits indefinitely; err tied to 0.
// TESTING
//  rst_n low 3 cycles then high, req=0 -> sys_rst_n=0 for exactly 18 edges
//   after release, then 1; busy 1->0 together; auto_cnt=0.
//  req 0->1 in IDLE, held until ack -> sys_rst_n low 4 cycles starting on the
//   3rd edge; ack=1 on the edge sys_rst_n returns; drop req -> ack=0 after
//   3 edges; auto_cnt=1.
//  req pulsed high 3 cycles only -> full 4-cycle pulse, ack high 1-3 cycles,
//   return to IDLE, auto_cnt increments by 1.
//  rst_n asserted during cycle 2 of ASSERT -> sys_rst_n stays 0, ack=0,
//   auto_cnt=0; after release, HOLD sequence of 18 edges repeats.
//  CNT_W=2, 5 handshakes -> auto_cnt reads 1,2,3,3,3.
//  With VEND_RST_TIMEOUT_EN, TIMEOUT_CYCLES=10, req held high -> err=1 and
//   ack=0 after 10 ACK cycles; no second pulse until req low, then high.

Source files
------------

// File: rtl/vend_reset_seq.sv
// Purpose: sequences the board reset and the FSM auto-reset requests into one registered sys_rst_n.
// Latency: sys_rst_n rises 2+HOLD_CYCLES edges after rst_n release; an auto pulse starts 3 edges after req is first sampled.
// Backpressure: 4-phase req/ack; ack holds until req_s drops (optional ACK timeout: VEND_RST_TIMEOUT_EN).
module vend_reset_seq #(
    parameter int HOLD_CYCLES    = 16,
    parameter int PULSE_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    output logic             sys_rst_n,
    output logic             ack,
    output logic             busy,
    output logic [CNT_W-1:0] auto_cnt,
    output logic             err
);

    // One shared phase counter, sized for the longest interval it has to time.
    localparam int MAX_HP  = (HOLD_CYCLES > PULSE_CYCLES) ? HOLD_CYCLES : PULSE_CYCLES;
    localparam int MAX_ALL = (MAX_HP > TIMEOUT_CYCLES) ? MAX_HP : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(MAX_ALL + 1);

    // Terminal counts: the counter is cleared on state entry, so the exit
    // edge is the one that sees N-1.
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
`ifdef VEND_RST_TIMEOUT_EN
    localparam logic [CW-1:0] TMO_LAST   = CW'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        S_HOLD   = 2'd0,
        S_IDLE   = 2'd1,
        S_ASSERT = 2'd2,
        S_ACK    = 2'd3
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            rst_m;
    logic            rst_s;
    logic            req_m;
    logic            req_s;

`ifdef VEND_RST_TIMEOUT_EN
    // Set after a timeout so IDLE ignores the same stuck-high request.
    logic            rearm_blk;
`endif

    // Board reset: asserts immediately, release is re-timed through two flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_m <= 1'b0;
            rst_s <= 1'b0;
        end else begin
            rst_m <= 1'b1;
            rst_s <= rst_m;
        end
    end

    // Request arrives from another timing domain; plain level synchronizer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_m <= 1'b0;
            req_s <= 1'b0;
        end else begin
            req_m <= req;
            req_s <= req_m;
        end
    end

    // Sequencer FSM; every output is a register written alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_HOLD;
            cnt       <= '0;
            sys_rst_n <= 1'b0;
            busy      <= 1'b1;
            ack       <= 1'b0;
            auto_cnt  <= '0;
`ifdef VEND_RST_TIMEOUT_EN
            err       <= 1'b0;
            rearm_blk <= 1'b0;
`endif
        end else begin
            case (state)
                // Stretch the board reset once the synchronized release lands.
                S_HOLD: begin
                    if (rst_s) begin
                        if (cnt == HOLD_LAST) begin
                            state     <= S_IDLE;
                            cnt       <= '0;
                            sys_rst_n <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                // Wait for a request level; no edge detection.
                S_IDLE: begin
`ifdef VEND_RST_TIMEOUT_EN
                    if (rear_blk_hold(rearm_blk)) begin
                        if (!req_s) begin
                            rearm_blk <= 1'b0;
                        end
                    end else if (req_s) begin
                        state     <= S_ASSERT;
                        cnt       <= '0;
                        sys_rst_n <= 1'b0;
                        busy      <= 1'b1;
                    end
`else
                    if (req_s) begin
                        state     <= S_ASSERT;
                        cnt       <= '0;
                        sys_rst_n <= 1'b0;
                        busy      <= 1'b1;
                    end
`endif
                end

                // Fixed-width pulse, independent of what req does meanwhile.
                S_ASSERT: begin
                    if (cnt == PULSE_LAST) begin
                        state     <= S_ACK;
                        cnt       <= '0;
                        sys_rst_n <= 1'b1;
                        busy      <= 1'b0;
                        ack       <= 1'b1;
                        if (auto_cnt != '1) begin
                            auto_cnt <= auto_cnt + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Hold ack until the requester withdraws; a stuck req never retriggers.
                S_ACK: begin
                    if (!req_s) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        ack   <= 1'b0;
`ifdef VEND_RST_TIMEOUT_EN
                    end else if (cnt == TMO_LAST) begin
                        state     <= S_IDLE;
                        cnt       <= '0;
                        ack       <= 1'b0;
                        err       <= 1'b1;
                        rearm_blk <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
`endif
                    end
                end

                default: begin
                    state     <= S_HOLD;
                    cnt       <= '0;
                    sys_rst_n <= 1'b0;
                    busy      <= 1'b1;
                    ack       <= 1'b0;
                end
            endcase
        end
    end

`ifdef VEND_RST_TIMEOUT_EN
    // Readability helper for the IDLE re-arm test.
    function automatic logic rear_blk_hold(input logic blk);
        return blk;
    endfunction
`else
    // Without the timeout there is nothing that can flag an error.
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_vend_reset_seq.sv
// Purpose: directed self-checking bench for vend_reset_seq (per-cycle vector table plus corner sequences).
// Latency: inputs change on the falling edge, outputs are sampled on the following falling edge.
// Backpressure: drives the req/ack handshake directly; every wait is bounded.
module tb_vend_reset_seq;

    localparam int CNT_W = 2;

    logic             clk;
    logic             rst_n;
    logic             req;
    logic             sys_rst_n;
    logic             ack;
    logic             busy;
    logic [CNT_W-1:0] auto_cnt;
    logic             err;

    int nchecks = 0;
    int nfail   = 0;

    vend_reset_seq #(
        .HOLD_CYCLES   (16),
        .PULSE_CYCLES  (4),
        .TIMEOUT_CYCLES(10),
        .CNT_W         (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .sys_rst_n(sys_rst_n),
        .ack      (ack),
        .busy     (busy),
        .auto_cnt (auto_cnt),
        .err      (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic rst_n;
        logic req;
        logic sys;
        logic ack;
        logic busy;
        int   cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic q, input logic s,
                                input logic a, input logic b, input int c);
        vec_t v;
        v.rst_n = r;
        v.req   = q;
        v.sys   = s;
        v.ack   = a;
        v.busy  = b;
        v.cnt   = c;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        nchecks++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Full handshake: raise req, hold until ack, drop, wait for ack to clear.
    task automatic handshake(input string tag, input int exp_cnt);
        int lat;
        int width;
        int drop;
        int ack_rise;
        lat = 0; width = 0; drop = 0; ack_rise = 0;
        req = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (!sys_rst_n) begin
                lat = k;
                break;
            end
        end
        for (int k = 0; k < 20; k++) begin
            if (sys_rst_n) break;
            step();
            width++;
        end
        ack_rise = int'(ack);
        req = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (!ack) begin
                drop = k;
                break;
            end
        end
        check({tag, "_latency"}, lat, 3);
        check({tag, "_width"}, width, 4);
        check({tag, "_ack_at_rise"}, ack_rise, 1);
        check({tag, "_ack_drop_edges"}, drop, 3);
        check({tag, "_auto_cnt"}, int'(auto_cnt), exp_cnt);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_low;
        int width;
        int ackc;
        int n_rel;
        int lows;
        int ackh;

        // Vector table: reset release and stretch, then one held handshake.
        for (int n = 1; n <= 20; n++) begin
            tbl.push_back(mk(1'b1, 1'b0, n >= 18, 1'b0, n < 18, 0));
        end
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0)); // edge 21: req first sampled
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0)); // 22
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0)); // 23: pulse starts
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0)); // 24
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0)); // 25
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0)); // 26
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1)); // 27: pulse ends, ack
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1)); // 28
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1)); // 29
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1)); // 30: req dropped
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1)); // 31
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1)); // 32: ack clears
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1)); // 33

        rst_n = 1'b0;
        req   = 1'b0;
        step();
        step();
        step();
        check("rst_sys", int'(sys_rst_n), 0);
        check("rst_busy", int'(busy), 1);
        check("rst_ack", int'(ack), 0);
        check("rst_auto_cnt", int'(auto_cnt), 0);
        check("rst_err", int'(err), 0);

        foreach (tbl[i]) begin
            rst_n = tbl[i].rst_n;
            req   = tbl[i].req;
            step();
            check($sformatf("vec%0d_sys", i), int'(sys_rst_n), int'(tbl[i].sys));
            check($sformatf("vec%0d_ack", i), int'(ack), int'(tbl[i].ack));
            check($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].busy));
            check($sformatf("vec%0d_cnt", i), int'(auto_cnt), tbl[i].cnt);
        end
        check("vec_err", int'(err), 0);

        // Short request: req high for 3 edges only; pulse still full width.
        first_low = 0; width = 0; ackc = 0;
        for (int k = 1; k <= 12; k++) begin
            req = (k <= 3);
            step();
            if (!sys_rst_n) begin
                if (first_low == 0) first_low = k;
                width++;
            end
            if (ack) ackc++;
        end
        check("short_latency", first_low, 3);
        check("short_width", width, 4);
        check("short_ack_cycles_1to3", int'(ackc >= 1 && ackc <= 3), 1);
        check("short_idle_sys", int'(sys_rst_n), 1);
        check("short_idle_busy", int'(busy), 0);
        check("short_auto_cnt", int'(auto_cnt), 2);

        // Remaining handshakes drive the 2-bit counter into saturation.
        handshake("hs3", 3);
        handshake("hs4", 3);
        handshake("hs5", 3);

        // Board reset during the second cycle of a pulse.
        req = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (!sys_rst_n) break;
        end
        step();
        check("mid_in_assert", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_sys", int'(sys_rst_n), 0);
        check("mid_rst_ack", int'(ack), 0);
        check("mid_rst_busy", int'(busy), 1);
        check("mid_rst_auto_cnt", int'(auto_cnt), 0);
        req = 1'b0;
        @(negedge clk);
        step();
        step();
        rst_n = 1'b1;
        n_rel = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (sys_rst_n) begin
                n_rel = k;
                break;
            end
        end
        check("mid_release_edges", n_rel, 18);
        check("mid_release_busy", int'(busy), 0);
        check("mid_release_auto_cnt", int'(auto_cnt), 0);

        // Request stuck high after the pulse.
        req = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (ack) break;
        end
        check("stuck_ack_seen", int'(ack), 1);
        check("stuck_auto_cnt", int'(auto_cnt), 1);
`ifdef VEND_RST_TIMEOUT_EN
        ackh = 1;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (!ack) break;
            ackh++;
        end
        check("tmo_ack_cycles", ackh, 10);
        check("tmo_err", int'(err), 1);
        lows = 0;
        for (int k = 1; k <= 15; k++) begin
            step();
            if (!sys_rst_n) lows++;
            if (ack) lows++;
        end
        check("tmo_no_retrigger", lows, 0);
        req = 1'b0;
        for (int k = 1; k <= 4; k++) step();
        req = 1'b1;
        first_low = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (!sys_rst_n) begin
                first_low = k;
                break;
            end
        end
        check("tmo_rearm_latency", first_low, 3);
        check("tmo_err_sticky", int'(err), 1);
        req = 1'b0;
        for (int k = 1; k <= 12; k++) step();
        check("tmo_rearm_auto_cnt", int'(auto_cnt), 2);
`else
        lows = 0; ackh = 0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (!sys_rst_n) lows++;
            if (ack) ackh++;
        end
        check("stuck_no_retrigger", lows, 0);
        check("stuck_ack_held", ackh, 30);
        check("stuck_err", int'(err), 0);
        check("stuck_auto_cnt_after", int'(auto_cnt), 1);
        req = 1'b0;
        for (int k = 1; k <= 4; k++) step();
        check("stuck_ack_cleared", int'(ack), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule
